fifo_bh_threshold: RTL and testbench

- Parametrised synchronous FIFO with first-word-fall-through (FWFT) read data, for any depth, not only powers of two.
- Next generation of the team's almost-full FIFO. Adds:
  - full/empty protection (blocked pushes and pops are ignored)
  - programmable almost-full and almost-empty thresholds
  - an occupancy count output
- Sits between packet producers and the read-request logic in the ASIC datapath.

---
 rtl/fifo_bh_pkg.sv | 24 ++
 rtl/fifo_bh_wrap_ctr.sv | 36 +++
 rtl/fifo_bh_threshold.sv | 128 ++++++++++++
 tb/tb_fifo_bh_threshold.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_bh_pkg.sv
// fifo_bh_pkg: shared helpers for the fifo_bh_threshold FIFO.
//   clog2          - ceiling log2 used to validate the pointer width
//   depth_ok       - DEPTH >= 2 and DEPTH_LG2 == clog2(DEPTH)
//   thresholds_ok  - AF_SPACE in 1..DEPTH, AE_LEVEL in 0..DEPTH-1
package fifo_bh_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic bit depth_ok(input int depth, input int depth_lg2);
    return (depth >= 2) && (depth_lg2 == int'(clog2(depth)));
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af_space,
                                       input int ae_level);
    return (af_space >= 1) && (af_space <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_bh_wrap_ctr.sv
// fifo_bh_wrap_ctr: W-bit pointer counter that wraps DEPTH-1 -> 0, so any
// depth (not only powers of two) is addressed without gaps.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears counter to 0
//   en_i   in   advance by one
//   cnt_o  out  current pointer value
module fifo_bh_wrap_ctr
  import fifo_bh_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_bh_threshold.sv
// fifo_bh_threshold: synchronous FWFT FIFO of any depth with full/empty
// protection, almost-full / almost-empty thresholds and an occupancy count.
// Optional feature macro: FIFO_BH_ERR_FLAGS_EN (sticky overflow/underflow
// flags plus simulation assertions; when undefined both flags read 0).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   wren_i/wdata_i  push request and data
//   rden_i          pop request
//   rdata_o         head entry, combinational (valid when empty_o=0)
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o  count decodes
//   overflow_o, underflow_o  sticky error flags
module fifo_bh_threshold
  import fifo_bh_pkg::*;
#(
  parameter int DATA_WIDTH = 66,
  parameter int DEPTH      = 14,
  parameter int DEPTH_LG2  = 4,
  parameter int AF_SPACE   = 7,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wren_i,
  input  logic                  rden_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_LG2:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int CW = DEPTH_LG2 + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_SPACE);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

  if (!depth_ok(DEPTH, DEPTH_LG2) ||
      !thresholds_ok(DEPTH, AF_SPACE, AE_LEVEL)) begin : g_bad_params
    $error("fifo_bh_threshold: illegal DEPTH/DEPTH_LG2/AF_SPACE/AE_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH_LG2-1:0]  wrptr, rdptr;
  logic                  push_ok, pop_ok;

  // A push at full is still accepted when a pop frees the head slot in the
  // same cycle; a pop at empty is always refused.
  assign push_ok = wren_i & (~full_o | rden_i);
  assign pop_ok  = rden_i & ~empty_o;

  fifo_bh_wrap_ctr #(.DEPTH(DEPTH), .W(DEPTH_LG2)) u_wrptr (
    .clk(clk), .reset(reset), .en_i(push_ok), .cnt_o(wrptr)
  );

  fifo_bh_wrap_ctr #(.DEPTH(DEPTH), .W(DEPTH_LG2)) u_rdptr (
    .clk(clk), .reset(reset), .en_i(pop_ok), .cnt_o(rdptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wrptr] = wdata_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign rdata_o        = mem_q[rdptr];
  assign count_o        = count_q;
  assign full_o         = (count_q == FULL_LVL);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q > AF_LVL);
  assign almost_empty_o = (count_q <= AE_LVL);

`ifdef FIFO_BH_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Any refused request is an error, including a pop that coincides with a
  // push into an empty FIFO.
  always_comb begin
    overflow_d  = overflow_q  | (wren_i & ~push_ok);
    underflow_d = underflow_q | (rden_i & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wren_i && !push_ok)) else $warning("fifo_bh_threshold: push refused");
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(rden_i && !pop_ok)) else $warning("fifo_bh_threshold: pop refused");
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_bh_threshold.sv
module tb_fifo_bh_threshold;

  localparam int DW = 66;

`ifdef FIFO_BH_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk, reset, wren_i, rden_i;
  logic [DW-1:0] wdata_i, rdata_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0]    count_o;
  logic          overflow_o, underflow_o;

  fifo_bh_threshold dut (
    .clk(clk), .reset(reset), .wren_i(wren_i), .rden_i(rden_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst, wr, rd;
    logic [DW-1:0] wd;
    logic [4:0]    cnt;
    logic [DW-1:0] rdat;
    logic          chk_rd;
    logic          full, empty, af, ae, of, uf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic rd,
                       input logic [DW-1:0] wd);
    reset = rst; wren_i = wr; rden_i = rd; wdata_i = wd;
  endtask

  // Sample one time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, wr, rd, input logic [DW-1:0] wd,
                              input logic [4:0] cnt, input logic [DW-1:0] rdat,
                              input logic chk_rd, input logic of, uf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.rdat = rdat; v.chk_rd = chk_rd;
    v.full = (cnt == 5'd14); v.empty = (cnt == 5'd0);
    v.af = (cnt > 5'd7); v.ae = (cnt <= 5'd2);
    v.of = of; v.uf = uf;
    return v;
  endfunction

  task automatic chk_flags(input string tag, input logic [4:0] cnt);
    chk({tag, " count"}, DW'(count_o), DW'(cnt));
    chk({tag, " full"}, DW'(full_o), DW'(cnt == 5'd14));
    chk({tag, " empty"}, DW'(empty_o), DW'(cnt == 5'd0));
    chk({tag, " almost_full"}, DW'(almost_full_o), DW'(cnt > 5'd7));
    chk({tag, " almost_empty"}, DW'(almost_empty_o), DW'(cnt <= 5'd2));
  endtask

  logic [DW-1:0] sb[$];
  int            mcnt;
  logic          wr, rd, p_ok, q_ok;
  logic [DW-1:0] wd;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0);

    // Reset with a push request that reset must override.
    vecs.push_back(mk(1, 1, 0, DW'(66'h99), 0, '0, 1, 0, 0));
    // 14 pushes 0x1..0xE: head stays 0x1, af after the 8th, full after 14th.
    for (int i = 1; i <= 14; i++)
      vecs.push_back(mk(0, 1, 0, DW'(i), 5'(i), DW'(1), 1, 0, 0));
    // Push at full is ignored.
    vecs.push_back(mk(0, 1, 0, DW'(66'hFF), 14, DW'(1), 1, ERR_EN, 0));
    // Pops return 0x1..0xE in order; after pop k the head is k+1.
    for (int k = 1; k <= 14; k++)
      vecs.push_back(mk(0, 0, 1, '0, 5'(14 - k), DW'(k + 1), k < 14, ERR_EN, 0));
    // Empty, push 0xAA with a pop: pop refused, push lands.
    vecs.push_back(mk(0, 1, 1, DW'(66'hAA), 1, DW'(66'hAA), 1, ERR_EN, ERR_EN));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wd);
      tick();
      chk($sformatf("vec%0d count", i), DW'(count_o), DW'(vecs[i].cnt));
      chk($sformatf("vec%0d full", i), DW'(full_o), DW'(vecs[i].full));
      chk($sformatf("vec%0d empty", i), DW'(empty_o), DW'(vecs[i].empty));
      chk($sformatf("vec%0d almost_full", i), DW'(almost_full_o), DW'(vecs[i].af));
      chk($sformatf("vec%0d almost_empty", i), DW'(almost_empty_o), DW'(vecs[i].ae));
      chk($sformatf("vec%0d overflow", i), DW'(overflow_o), DW'(vecs[i].of));
      chk($sformatf("vec%0d underflow", i), DW'(underflow_o), DW'(vecs[i].uf));
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d rdata", i), rdata_o, vecs[i].rdat);
    end

    // Simultaneous push+pop at full: drain 0xAA, refill with 0x1..0xE.
    drive(0, 0, 1, '0); tick();
    chk_flags("drain", 0);
    for (int i = 1; i <= 14; i++) begin
      drive(0, 1, 0, DW'(i)); tick();
    end
    chk_flags("refill", 14);
    drive(0, 1, 1, DW'(66'h55));
    chk("full rw old head", rdata_o, DW'(1));
    tick();
    chk_flags("full rw", 14);
    chk("full rw new head", rdata_o, DW'(2));
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("full rw pop%0d head", k + 1), rdata_o,
          (k < 13) ? DW'(k + 2) : DW'(66'h55));
      drive(0, 0, 1, '0); tick();
    end
    chk_flags("full rw drained", 0);

    // Wrap test: 40 push/pop pairs against a scoreboard.
    mcnt = 0;
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        wr = (ph == 0) ? 1'b1 : (i % 3 == 0);
        rd = (ph == 1) ? 1'b1 : (i % 4 == 3);
        wd = {2'(i), $urandom, $urandom};
        p_ok = wr && (mcnt != 14 || rd);
        q_ok = rd && (mcnt != 0);
        drive(0, wr, rd, wd);
        tick();
        if (q_ok) void'(sb.pop_front());
        if (p_ok) sb.push_back(wd);
        mcnt = mcnt + (p_ok ? 1 : 0) - (q_ok ? 1 : 0);
        chk_flags($sformatf("wrap%0d.%0d", i, ph), 5'(mcnt));
        if (mcnt > 0)
          chk($sformatf("wrap%0d.%0d rdata", i, ph), rdata_o, sb[0]);
      end
    end

    // Reset at count=9 with a push in the same cycle.
    drive(1, 0, 0, '0); tick();
    for (int i = 1; i <= 9; i++) begin
      drive(0, 1, 0, DW'(66'h100 + i)); tick();
    end
    chk_flags("pre-reset", 9);
    drive(1, 1, 0, DW'(66'h77)); tick();
    chk_flags("mid reset", 0);
    chk("mid reset rdata", rdata_o, '0);
    chk("mid reset overflow", DW'(overflow_o), '0);
    chk("mid reset underflow", DW'(underflow_o), '0);
    drive(0, 0, 0, '0); tick();
    chk_flags("post reset idle", 0);
    chk("post reset rdata", rdata_o, '0);
    drive(0, 1, 0, DW'(66'h33)); tick();
    chk_flags("post reset push", 1);
    chk("post reset push rdata", rdata_o, DW'(66'h33));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
